fir_fold_sequencer: RTL
=======================

Name: fir_fold_sequencer

Overview:
- Folded 9-tap FIR controller: one shared signed multiplier and one accumulator, time-multiplexed across all taps by an FSM.
- Functionally equivalent to the team's parallel 9-tap FIR (same default coefficients, 40-bit output), trading throughput for area.
- Sits between an upstream sample source and a downstream sink, both using valid/ready handshakes.
- Coefficients are runtime-writable through a simple config port.

Parameters:
- NTAPS, 9, number of taps and delay-line depth (delay line has NTAPS entries, including the newest sample).
- DW, 17, signed sample width.
- CW, 17, signed coefficient width.
- AW, 40, signed accumulator/output width; must be >= DW+CW+ceil(log2(NTAPS)).

Ports:
- clock95  in  1  single clock, rising edge.
- reset95  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample.
- in_sample  in  DW  signed input sample.
- out_valid  out  1  filtered result valid.
- out_ready  in  1  downstream accepts result.
- out_sample  out  AW  signed filtered result.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  coefficient index, 0..NTAPS-1.
- coef_data  in  CW  signed coefficient value.
- coef_err  out  1  one-cycle pulse: a coefficient write was rejected.
- busy  out  1  high while in MAC state.

Behaviour:
- Reset is synchronous: every register updates only on a clock95 edge with reset95=1.
- Reset values:
  - State = IDLE.
  - Delay line x[0..NTAPS-1] = 0; acc = 0; tap index k = 0.
  - out_valid = 0, out_sample = 0, coef_err = 0, busy = 0.
  - Coefficients = -409, 769, 8928, 24338, 32768, 24338, 8928, 769, -409 (index 0..8).
- in_ready = (state==IDLE) && !reset95.
- States IDLE, MAC, HOLD:
  - **IDLE:** on in_valid && in_ready:
    - Shift delay line x[j] <= x[j-1], x[0] <= in_sample.
    - acc <= 0, k <= 0, go to MAC.
  - **MAC:** each cycle acc <= acc + sext(coef[k] * x[k]), k <= k+1.
    - On the cycle with k==NTAPS-1: out_sample <= final sum, out_valid <= 1, go to HOLD.
  - **HOLD:** out_valid and out_sample stay stable until out_ready=1.
    - That cycle: out_valid <= 0, go to IDLE.
  - MAC always uses the updated delay line, so x[0] is the sample just accepted.
- Latency:
  - Acceptance edge at cycle T; out_valid high from cycle T+NTAPS (the 9th edge after acceptance).
  - Minimum period between accepted samples is NTAPS+2 cycles (out_ready held high).
- Arithmetic:
  - Signed DWxCW product, sign-extended to AW, added modulo 2^AW.
  - No saturation; cannot overflow at default widths.
- Coefficient writes:
  - Accepted in IDLE or HOLD when coef_addr < NTAPS; coef[coef_addr] <= coef_data on that edge.
  - Rejected, with coef_err pulsed for one cycle and coefficients unchanged, when either:
    - state is MAC, or
    - coef_addr >= NTAPS.
  - A write in the same cycle as a sample acceptance takes effect before that sample's MAC.
- Simultaneous in_valid while not IDLE: ignored (in_ready=0); upstream must hold the sample.
- Reset mid-MAC or mid-HOLD: the result in flight is discarded, out_valid drops after the reset edge, and the delay line is cleared.

Test Plan:
- **Impulse:** samples 1,0,0,0,0,0,0,0,0 with out_ready=1 -> outputs -409, 769, 8928, 24338, 32768, 24338, 8928, 769, -409.
- **Step:** nine or more samples of 100 -> the 9th and later outputs equal 10002000; the first output is -40900.
- **Latency/throughput:** accept at cycle T, out_ready=1 -> out_valid first high at T+9; next in_ready at T+10; back-to-back samples spaced 11 cycles.
- **Backpressure:** hold out_ready=0 for 5 cycles in HOLD -> out_valid and out_sample stable and in_ready=0 throughout; completes the cycle out_ready rises.
- **Coefficient config:**
  - Write coef[4]=1000 in IDLE, then impulse of 2 -> 5th output = 2000.
  - Write during MAC -> coef_err pulses and the result is unchanged.
  - Write with coef_addr=9 -> coef_err pulses.
- **Reset mid-MAC:** assert reset95 for one edge at k=4 -> out_valid stays 0, then in_ready=1; the next impulse of 1 reproduces the default impulse response from -409.

Source files
------------

// File: rtl/fir_fold_sequencer.sv
// rtl/fir_fold_sequencer.sv - folded 9-tap FIR: one shared signed MAC sequenced across all taps
module fir_fold_sequencer #(
    parameter int NTAPS = 9,
    parameter int DW    = 17,
    parameter int CW    = 17,
    parameter int AW    = 40
) (
    input  logic          clock95,
    input  logic          reset95,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sample,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sample,
    input  logic          coef_we,
    input  logic [3:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          coef_err,
    output logic          busy
);

    localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PW = DW + CW;
    localparam logic [KW-1:0] LAST_K = KW'(NTAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

    state_t               state;
    state_t               state_nxt;
    logic signed [DW-1:0] x    [NTAPS];
    logic signed [CW-1:0] coef [NTAPS];
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;
    logic signed [PW-1:0] prod;
    logic [KW-1:0]        k;
    logic                 accept;
    logic                 coef_ok;

    function automatic logic signed [CW-1:0] default_coef(input int i);
        logic signed [CW-1:0] c;
        case (i)
            0, 8:    c = CW'(-409);
            1, 7:    c = CW'(769);
            2, 6:    c = CW'(8928);
            3, 5:    c = CW'(24338);
            4:       c = CW'(32768);
            default: c = '0;
        endcase
        return c;
    endfunction

    assign in_ready = (state == IDLE) && !reset95;
    assign busy     = (state == MAC);
    // Coefficients are frozen while the MAC walks the taps.
    assign coef_ok  = (state != MAC) && (int'(coef_addr) < NTAPS);

    assign prod    = x[k] * coef[k];
    assign acc_sum = acc + {{(AW-PW){prod[PW-1]}}, prod};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (k == LAST_K) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock95) begin
        if (reset95) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock95) begin
        if (reset95) begin
            for (int i = 0; i < NTAPS; i++) begin
                x[i]    <= '0;
                coef[i] <= default_coef(i);
            end
            acc        <= '0;
            k          <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            coef_err   <= 1'b0;
        end else begin
            coef_err <= 1'b0;
            if (coef_we) begin
                if (coef_ok) begin
                    coef[coef_addr] <= coef_data;
                end else begin
                    coef_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int j = NTAPS - 1; j > 0; j--) begin
                            x[j] <= x[j-1];
                        end
                        x[0] <= in_sample;
                        acc  <= '0;
                        k    <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (k == LAST_K) begin
                        k          <= '0;
                        out_sample <= acc_sum;
                        out_valid  <= 1'b1;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
